// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - radix-2 restoring sequential divider, one quotient bit per clock
// Optional two's-complement operation when SIGNED_DIV_EN is defined.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] rem_q, sh_q, div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   rem_sh, trial;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, q_nx;
  logic [WIDTH-1:0] x_mag, y_mag, q_fix, r_fix;

`ifdef SIGNED_DIV_EN
  logic             neg_q, neg_r;
`endif

  // One restoring step; the extra trial bit keeps divisors with MSB set from overflowing.
  always_comb begin
    rem_sh = {rem_q, sh_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, div_q};
    ge     = ~trial[WIDTH];
    rem_nx = ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    q_nx   = {sh_q[WIDTH-2:0], ge};
  end

  always_comb begin
    x_mag = X;
    y_mag = Y;
    q_fix = q_nx;
    r_fix = rem_nx;
`ifdef SIGNED_DIV_EN
    if (X[WIDTH-1]) x_mag = -X;
    if (Y[WIDTH-1]) y_mag = -Y;
    if (neg_q) q_fix = -q_nx;
    if (neg_r) r_fix = -rem_nx;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = (Y == '0) ? FIN : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt_q == CW'(1)) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      sh_q      <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          if (Y != '0) begin
            rem_q <= '0;
            sh_q  <= x_mag;
            div_q <= y_mag;
            cnt_q <= CW'(WIDTH);
            dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q <= X[WIDTH-1] ^ Y[WIDTH-1];
            neg_r <= X[WIDTH-1];
`endif
          end else begin
            quotient  <= '1;
            remainder <= X;
            dbz       <= 1'b1;
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          sh_q  <= q_nx;
          cnt_q <= cnt_q - CW'(1);
          // Last step lands straight in the result registers as FIN is entered.
          if (cnt_q == CW'(1)) begin
            quotient  <= q_fix;
            remainder <= r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] xin = '0, yin = '0;
  logic        busy, done, dbz;
  logic [15:0] quotient, remainder;

  logic        start8 = 1'b0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  int asserts = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(xin), .Y(yin),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .X(x8), .Y(y8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .dbz(dbz8)
  );

  // n counts edges after the accepting edge k; samples are taken on the following negedge.
  task automatic div16(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] q, output logic [15:0] r, output logic z,
                       output int done_at, output int busy_cnt, output int done_cnt);
    done_at = -1; busy_cnt = 0; done_cnt = 0; q = '0; r = '0; z = 1'b0;
    @(negedge clk); start = 1'b1; xin = x; yin = y;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n; q = quotient; r = remainder; z = dbz;
        end
      end
      if (done_at >= 0 && n > done_at + 1) break;
    end
  endtask

  task automatic test_reset();
    int seen;
    repeat (2) @(negedge clk);
    asserts++;
    if ({busy, done, dbz, quotient, remainder} !== 35'd0) begin
      failures++; $display("FAIL reset_outputs got %h exp 0", {busy, done, dbz, quotient, remainder});
    end
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1; xin = 16'd1000; yin = 16'd7;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({busy, done, dbz, quotient, remainder} !== 35'd0) begin
      failures++; $display("FAIL reset_abort got %h exp 0", {busy, done, dbz, quotient, remainder});
    end
    seen = 0;
    repeat (3) @(negedge clk) if (done) seen++;
    rst_n = 1'b1;
    repeat (25) @(negedge clk) if (done) seen++;
    asserts++;
    if (seen !== 0) begin
      failures++; $display("FAIL reset_no_done got %0d pulses exp 0", seen);
    end
    asserts++;
    if ({busy, dbz, quotient, remainder} !== 34'd0) begin
      failures++; $display("FAIL reset_after_release got %h exp 0", {busy, dbz, quotient, remainder});
    end
    begin
      logic [15:0] q, r; logic z; int da, bc, dc;
      div16(16'd100, 16'd9, q, r, z, da, bc, dc);
      asserts++;
      if (q !== 16'd11 || r !== 16'd1 || z !== 1'b0) begin
        failures++; $display("FAIL reset_then_100_9 got q=%0d r=%0d z=%0b exp q=11 r=1 z=0", q, r, z);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] q, r; logic z; int da, bc, dc;
    div16(16'd50000, 16'd123, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'd406 || r !== 16'd62 || z !== 1'b0) begin
      failures++; $display("FAIL basic_50000_123 got q=%0d r=%0d z=%0b exp q=406 r=62 z=0", q, r, z);
    end
    asserts++;
    if (da !== 16 || bc !== 16 || dc !== 1) begin
      failures++; $display("FAIL basic_latency got done_at=%0d busy=%0d pulses=%0d exp 16 16 1", da, bc, dc);
    end
    div16(16'd0, 16'd7, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'd0 || r !== 16'd0 || da !== 16) begin
      failures++; $display("FAIL zero_dividend got q=%0d r=%0d done_at=%0d exp 0 0 16", q, r, da);
    end
    div16(16'd65535, 16'd32768, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'd1 || r !== 16'd32767) begin
      failures++; $display("FAIL msb_divisor got q=%0d r=%0d exp q=1 r=32767", q, r);
    end
    div16(16'd65535, 16'd1, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'd65535 || r !== 16'd0) begin
      failures++; $display("FAIL div_by_one got q=%0d r=%0d exp q=65535 r=0", q, r);
    end
  endtask

  task automatic test_dbz();
    logic [15:0] q, r; logic z; int da, bc, dc;
    div16(16'd12345, 16'd0, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'hFFFF || r !== 16'd12345 || z !== 1'b1) begin
      failures++; $display("FAIL dbz_result got q=%h r=%0d z=%0b exp q=ffff r=12345 z=1", q, r, z);
    end
    asserts++;
    if (da !== 0 || bc !== 0 || dc !== 1) begin
      failures++; $display("FAIL dbz_latency got done_at=%0d busy=%0d pulses=%0d exp 0 0 1", da, bc, dc);
    end
    repeat (4) @(negedge clk);
    asserts++;
    if (quotient !== 16'hFFFF || remainder !== 16'd12345 || dbz !== 1'b1) begin
      failures++; $display("FAIL dbz_hold got q=%h r=%0d z=%0b exp ffff 12345 1", quotient, remainder, dbz);
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] q, r; logic z; int da, bc, dc;
    int done_at = -1, pulses = 0;
    logic [15:0] qq = '0, rr = '0;
    @(negedge clk); start = 1'b1; xin = 16'd65535; yin = 16'd65535;
    @(negedge clk); start = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (n > 0) @(negedge clk);
      start = (n == 3 || n == 8);
      xin = 16'd7; yin = 16'd3;
      if (done) begin
        pulses++;
        if (done_at < 0) begin done_at = n; qq = quotient; rr = remainder; end
      end
    end
    start = 1'b0;
    asserts++;
    if (qq !== 16'd1 || rr !== 16'd0 || done_at !== 16 || pulses !== 1) begin
      failures++; $display("FAIL ignore_start got q=%0d r=%0d done_at=%0d pulses=%0d exp 1 0 16 1", qq, rr, done_at, pulses);
    end
    div16(16'd5, 16'd65535, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'd0 || r !== 16'd5) begin
      failures++; $display("FAIL x_less_y got q=%0d r=%0d exp q=0 r=5", q, r);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = -1, d1 = -1, pulses = 0;
    @(negedge clk); start = 1'b1; xin = 16'd200; yin = 16'd7;
    for (int n = 0; n <= 35; n++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (d0 < 0) d0 = n; else if (d1 < 0) d1 = n;
        asserts++;
        if (quotient !== 16'd28 || remainder !== 16'd4) begin
          failures++; $display("FAIL b2b_result got q=%0d r=%0d exp q=28 r=4", quotient, remainder);
        end
      end
      if (n == 35) start = 1'b0;
    end
    asserts++;
    if (d0 !== 16 || d1 !== 34 || pulses !== 2) begin
      failures++; $display("FAIL b2b_spacing got d0=%0d d1=%0d pulses=%0d exp 16 34 2", d0, d1, pulses);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sweep8();
    int bad = 0;
    for (int y = 0; y < 256; y++) begin
      for (int xi = 0; xi < 16; xi++) begin
        int x, got;
        x = xi * 17;
        @(negedge clk); start8 = 1'b1; x8 = 8'(x); y8 = 8'(y);
        @(negedge clk); start8 = 1'b0;
        got = 0;
        for (int n = 0; n < 15 && got == 0; n++) begin
          if (n > 0) @(negedge clk);
          if (done8) got = 1;
        end
        asserts++;
        if (got == 0 ||
            (y == 0 && (dbz8 !== 1'b1 || q8 !== 8'hFF || r8 !== 8'(x))) ||
            (y != 0 && (dbz8 !== 1'b0 || int'(q8) * y + int'(r8) != x || int'(r8) >= y))) begin
          failures++; bad++;
          if (bad < 10)
            $display("FAIL sweep8 x=%0d y=%0d got q=%0d r=%0d dbz=%0b done=%0d", x, y, q8, r8, dbz8, got);
        end
      end
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed();
    logic [15:0] q, r; logic z; int da, bc, dc;
    div16(-16'sd7, 16'sd2, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'hFFFD || r !== 16'hFFFF || z !== 1'b0) begin
      failures++; $display("FAIL signed_m7_2 got q=%h r=%h exp fffd ffff", q, r);
    end
    div16(16'sd7, -16'sd2, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'hFFFD || r !== 16'h0001 || z !== 1'b0) begin
      failures++; $display("FAIL signed_7_m2 got q=%h r=%h exp fffd 0001", q, r);
    end
    div16(16'h8000, 16'hFFFF, q, r, z, da, bc, dc);
    asserts++;
    if (q !== 16'h8000 || r !== 16'h0000 || z !== 1'b0 || da !== 16) begin
      failures++; $display("FAIL signed_overflow got q=%h r=%h z=%0b done_at=%0d exp 8000 0000 0 16", q, r, z, da);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dbz();
`ifdef SIGNED_DIV_EN
    test_signed();
`else
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_sweep8();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
